ip_injector: RTL and testbench

IP_INJECTOR -- requirements
Module: ip_injector

---
 rtl/eth_sniffer_pkg.sv | 8 +
 rtl/ip_lane_merge.sv | 29 ++
 rtl/ip_injector.sv | 141 ++++++++++++++
 tb/tb_ip_injector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sniffer_pkg.sv
// Shared constants and the insertion FSM state type for the sniffer datapath.
package eth_sniffer_pkg;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;

    typedef enum logic [1:0] {IDLE, PRE, INS, POST} inj_state_e;
endpackage

// File: rtl/ip_lane_merge.sv
// Per-lane byte selection: lane L takes ip byte (4w+L-offset) when that index is 0..3.
module ip_lane_merge
    import eth_sniffer_pkg::*;
#(
    parameter int OFFSET_W = 8
) (
    input  logic [WORD_W-1:0]   word,
    input  logic [WORD_W-1:0]   ip,
    input  logic [OFFSET_W-1:0] w,
    input  logic [OFFSET_W-1:0] offset,
    output logic [WORD_W-1:0]   merged
);
    localparam int IDX_W = OFFSET_W + 2;

    logic [WORD_BYTES-1:0][BYTE_W-1:0] word_b, ip_b, merged_b;

    assign word_b = word;
    assign ip_b   = ip;
    assign merged = merged_b;

    for (genvar l = 0; l < WORD_BYTES; l++) begin : g_lane
        logic [IDX_W-1:0] idx, rel;
        assign idx = {w, 2'b00} + IDX_W'(l);
        assign rel = idx - IDX_W'(offset);
        // rel only meaningful once idx >= offset; upper bits catch out-of-field lanes
        assign merged_b[l] = (idx >= IDX_W'(offset) && rel < IDX_W'(WORD_BYTES))
                             ? ip_b[rel[1:0]] : word_b[l];
    end
endmodule

// File: rtl/ip_injector.sv
// Inserts a 4-byte IP address at a per-frame byte offset into a 32-bit stream.
// Optional IP_INJECT_STATS_EN adds a saturating ins_count output.
module ip_injector
    import eth_sniffer_pkg::*;
#(
    parameter int OFFSET_W = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic [WORD_W-1:0]   ip_in,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [WORD_W-1:0]   data_in,
    input  logic                in_valid,
    input  logic                sof,
    input  logic                eof,
    output logic                in_ready,
    output logic [WORD_W-1:0]   data_out,
    output logic                out_valid,
    output logic                out_sof,
    output logic                out_eof,
    input  logic                out_ready,
    output logic                inserted,
    output logic                trunc
`ifdef IP_INJECT_STATS_EN
    ,
    output logic [15:0]         ins_count
`endif
);
    inj_state_e          state_q;
    logic [WORD_W-1:0]   ip_q, data_q;
    logic [OFFSET_W-1:0] off_q, w_q;
    logic                oval_q, osof_q, oeof_q, ins_q, trunc_q;

    logic                accept, mid_frame, ins_en, hit_start, hit_end, fin_now;
    logic                ins_set, trunc_set;
    logic [WORD_W-1:0]   eff_ip, merged, word_d;
    logic [OFFSET_W-1:0] eff_off, eff_w, start_w, end_w;
    logic [OFFSET_W:0]   end_b;

    assign in_ready = !oval_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A sof beat is evaluated against its own ip/offset as word 0
    always_comb begin
        eff_off   = sof ? offset : off_q;
        eff_ip    = sof ? ip_in : ip_q;
        eff_w     = sof ? '0 : w_q;
        end_b     = {1'b0, eff_off} + (OFFSET_W+1)'(3);
        start_w   = OFFSET_W'(eff_off >> 2);
        end_w     = OFFSET_W'(end_b >> 2);
        hit_start = (eff_w == start_w);
        hit_end   = (eff_w == end_w);
        mid_frame = (state_q == PRE) || (state_q == INS);
        ins_en    = sof || (state_q != IDLE);
        fin_now   = sof ? (end_w == '0)
                        : ((state_q == PRE && hit_start && hit_end) || (state_q == INS && hit_end));
        ins_set   = accept && !clear && fin_now;
        trunc_set = accept && !clear &&
                    ((sof && mid_frame) || (eof && (sof ? (end_w != '0) : (mid_frame && !fin_now))));
        word_d    = ins_en ? merged : data_in;
    end

    ip_lane_merge #(.OFFSET_W(OFFSET_W)) u_merge (
        .word   (data_in),
        .ip     (eff_ip),
        .w      (eff_w),
        .offset (eff_off),
        .merged (merged)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            ip_q    <= '0;
            off_q   <= '0;
            w_q     <= '0;
            data_q  <= '0;
            oval_q  <= 1'b0;
            osof_q  <= 1'b0;
            oeof_q  <= 1'b0;
            ins_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            ins_q   <= ins_set;
            trunc_q <= trunc_set;
            if (clear) begin
                state_q <= IDLE;
                w_q     <= '0;
                data_q  <= '0;
                oval_q  <= 1'b0;
                osof_q  <= 1'b0;
                oeof_q  <= 1'b0;
            end else if (accept) begin
                oval_q <= 1'b1;
                data_q <= word_d;
                osof_q <= sof;
                oeof_q <= eof;
                if (sof) begin
                    ip_q  <= ip_in;
                    off_q <= offset;
                    w_q   <= eof ? '0 : OFFSET_W'(1);
                    if (eof)               state_q <= IDLE;
                    else if (start_w != '0) state_q <= PRE;
                    else if (end_w != '0)   state_q <= INS;
                    else                    state_q <= POST;
                end else begin
                    w_q <= eof ? '0 : ((&w_q) ? w_q : w_q + OFFSET_W'(1));
                    if (eof) begin
                        state_q <= IDLE;
                    end else begin
                        case (state_q)
                            PRE:     if (hit_start) state_q <= hit_end ? POST : INS;
                            INS:     if (hit_end) state_q <= POST;
                            default: ;
                        endcase
                    end
                end
            end else if (out_ready) begin
                oval_q <= 1'b0;
            end
        end
    end

    assign data_out  = data_q;
    assign out_valid = oval_q;
    assign out_sof   = osof_q;
    assign out_eof   = oeof_q;
    assign inserted  = ins_q;
    assign trunc     = trunc_q;

`ifdef IP_INJECT_STATS_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                   cnt_q <= '0;
        else if (clear)               cnt_q <= '0;
        else if (ins_set && !(&cnt_q)) cnt_q <= cnt_q + 16'd1;
    end
    assign ins_count = cnt_q;
`endif
endmodule

// File: tb/tb_ip_injector.sv
// Bench for ip_injector: directed vector table, hand-built corner sequences, randomized stream vs byte-level model.
module tb_ip_injector;
    logic        clk = 1'b0;
    logic        n_rst, clear, in_valid, sof, eof, out_ready;
    logic [31:0] ip_in, data_in, data_out;
    logic [7:0]  offset;
    logic        in_ready, out_valid, out_sof, out_eof, inserted, trunc;
`ifdef IP_INJECT_STATS_EN
    logic [15:0] ins_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ip_injector #(.OFFSET_W(8)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .ip_in(ip_in), .offset(offset),
        .data_in(data_in), .in_valid(in_valid), .sof(sof), .eof(eof), .in_ready(in_ready),
        .data_out(data_out), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
        .out_ready(out_ready), .inserted(inserted),
`ifdef IP_INJECT_STATS_EN
        .ins_count(ins_count),
`endif
        .trunc(trunc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-level reference: a frame is a byte array, the field occupies bytes off..off+3
    bit          m_in_frame, m_done;
    int          m_off, m_w;
    logic [31:0] m_ip, e_word;
    bit          e_ins, e_tr;

    task automatic model_step(input logic [31:0] d, input bit s, input bit e,
                              input logic [31:0] ip, input int off);
        e_ins = 0;
        e_tr  = 0;
        if (s) begin
            if (m_in_frame && !m_done) e_tr = 1;
            m_in_frame = 1; m_done = 0; m_off = off; m_ip = ip; m_w = 0;
        end
        for (int l = 0; l < 4; l++) begin
            int p;
            p = 4 * m_w + l;
            if (m_in_frame && p >= m_off && p <= m_off + 3) e_word[8*l +: 8] = m_ip[8*(p-m_off) +: 8];
            else                                            e_word[8*l +: 8] = d[8*l +: 8];
        end
        if (m_in_frame && !m_done && (m_off + 3) / 4 == m_w) begin
            e_ins = 1; m_done = 1;
        end
        if (e) begin
            if (m_in_frame && !m_done) e_tr = 1;
            m_in_frame = 0;
        end
        if (m_w < 255) m_w++;
    endtask

    task automatic beat(input logic [31:0] d, input bit s, input bit e,
                        input logic [31:0] ip, input logic [7:0] off);
        @(negedge clk);
        data_in = d; sof = s; eof = e; ip_in = ip; offset = off; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0; sof = 0; eof = 0;
    endtask

    typedef struct {
        logic [31:0] ip; logic [7:0] off; logic [31:0] d; bit s; bit e;
        logic [31:0] x; bit xi; bit xt;
    } vec_t;
    vec_t tbl[23];

    bit          mv, ms, me, mi, mt, exp_rdy;
    logic [31:0] md;

    initial begin
        tbl[0]  = '{32'hC0A80001, 8'd0,   32'hFFFFFFFF, 1, 0, 32'hC0A80001, 1, 0};
        tbl[1]  = '{32'hC0A80001, 8'd0,   32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 0, 0};
        tbl[2]  = '{32'hC0A80001, 8'd0,   32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 0, 0};
        tbl[3]  = '{32'h44332211, 8'd6,   32'hAAAAAAAA, 1, 0, 32'hAAAAAAAA, 0, 0};
        tbl[4]  = '{32'h44332211, 8'd6,   32'hAAAAAAAA, 0, 0, 32'h2211AAAA, 0, 0};
        tbl[5]  = '{32'h44332211, 8'd6,   32'hAAAAAAAA, 0, 1, 32'hAAAA4433, 1, 0};
        tbl[6]  = '{32'h11223344, 8'd20,  32'h12345678, 1, 0, 32'h12345678, 0, 0};
        tbl[7]  = '{32'h11223344, 8'd20,  32'h9ABCDEF0, 0, 0, 32'h9ABCDEF0, 0, 0};
        tbl[8]  = '{32'h11223344, 8'd20,  32'h0F0F0F0F, 0, 1, 32'h0F0F0F0F, 0, 1};
        tbl[9]  = '{32'h11223344, 8'd0,   32'h55555555, 0, 0, 32'h55555555, 0, 0};
        tbl[10] = '{32'hDDCCBBAA, 8'd2,   32'h00000000, 1, 0, 32'hBBAA0000, 0, 0};
        tbl[11] = '{32'h04030201, 8'd1,   32'h00000000, 1, 0, 32'h03020100, 0, 1};
        tbl[12] = '{32'h04030201, 8'd1,   32'h00000000, 0, 1, 32'h00000004, 1, 0};
        tbl[13] = '{32'h87654321, 8'd0,   32'h00000000, 1, 1, 32'h87654321, 1, 0};
        tbl[14] = '{32'h87654321, 8'd2,   32'hFFFFFFFF, 1, 1, 32'h4321FFFF, 0, 1};
        tbl[15] = '{32'hA1B2C3D4, 8'd4,   32'h00000000, 1, 0, 32'h00000000, 0, 0};
        tbl[16] = '{32'h00000000, 8'd0,   32'h00000000, 0, 0, 32'hA1B2C3D4, 1, 0};
        tbl[17] = '{32'h00000000, 8'd0,   32'h00000000, 0, 1, 32'h00000000, 0, 0};
        tbl[18] = '{32'h00000001, 8'd255, 32'h13572468, 1, 1, 32'h13572468, 0, 1};
        tbl[19] = '{32'hDDCCBBAA, 8'd3,   32'h00000000, 1, 0, 32'hAA000000, 0, 0};
        tbl[20] = '{32'hDDCCBBAA, 8'd3,   32'h00000000, 0, 1, 32'h00DDCCBB, 1, 0};
        tbl[21] = '{32'h11111111, 8'd9,   32'h00000000, 1, 0, 32'h00000000, 0, 0};
        tbl[22] = '{32'h0A0B0C0D, 8'd0,   32'h00000000, 1, 1, 32'h0A0B0C0D, 1, 1};

        n_rst = 0; clear = 0; in_valid = 0; sof = 0; eof = 0; out_ready = 1;
        ip_in = 32'hDEADBEEF; offset = 8'd0; data_in = 32'h12345678;
        repeat (2) @(posedge clk);
        #1;
        chk("rst data_out", data_out, 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_sof", 32'(out_sof), 32'h0);
        chk("rst out_eof", 32'(out_eof), 32'h0);
        chk("rst inserted", 32'(inserted), 32'h0);
        chk("rst trunc", 32'(trunc), 32'h0);
        chk("rst in_ready", 32'(in_ready), 32'h1);
        @(negedge clk); n_rst = 1;

        for (int i = 0; i < 23; i++) begin
            beat(tbl[i].d, tbl[i].s, tbl[i].e, tbl[i].ip, tbl[i].off);
            chk($sformatf("row%0d data", i), data_out, tbl[i].x);
            chk($sformatf("row%0d valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("row%0d sof", i), 32'(out_sof), 32'(tbl[i].s));
            chk($sformatf("row%0d eof", i), 32'(out_eof), 32'(tbl[i].e));
            chk($sformatf("row%0d inserted", i), 32'(inserted), 32'(tbl[i].xi));
            chk($sformatf("row%0d trunc", i), 32'(trunc), 32'(tbl[i].xt));
        end
        @(posedge clk); #1;
        chk("idle valid", 32'(out_valid), 32'h0);
        chk("idle inserted", 32'(inserted), 32'h0);
        chk("idle trunc", 32'(trunc), 32'h0);

        // Backpressure mid-frame: beat 1 waits three cycles, then flows
        beat(32'hAAAAAAAA, 1, 0, 32'h44332211, 8'd6);
        chk("stall w0", data_out, 32'hAAAAAAAA);
        @(negedge clk);
        out_ready = 0; data_in = 32'hAAAAAAAA; in_valid = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'h0);
            chk($sformatf("stall%0d valid", k), 32'(out_valid), 32'h1);
            chk($sformatf("stall%0d data", k), data_out, 32'hAAAAAAAA);
            chk($sformatf("stall%0d sof", k), 32'(out_sof), 32'h1);
        end
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1; in_valid = 0;
        chk("stall w1", data_out, 32'h2211AAAA);
        chk("stall w1 sof", 32'(out_sof), 32'h0);
        beat(32'hAAAAAAAA, 0, 1, 32'h44332211, 8'd6);
        chk("stall w2", data_out, 32'hAAAA4433);
        chk("stall inserted", 32'(inserted), 32'h1);
        @(posedge clk); #1;
        chk("stall no dup", 32'(out_valid), 32'h0);

        // Reset mid-frame discards the frame
        beat(32'h00000000, 1, 0, 32'h11223344, 8'd4);
        @(negedge clk); n_rst = 0; #1;
        chk("mrst data", data_out, 32'h0);
        chk("mrst valid", 32'(out_valid), 32'h0);
        chk("mrst sof", 32'(out_sof), 32'h0);
        @(negedge clk); n_rst = 1;
        beat(32'hCAFEF00D, 0, 0, 32'h11223344, 8'd4);
        chk("mrst pass", data_out, 32'hCAFEF00D);
        chk("mrst no ins", 32'(inserted), 32'h0);

        // Clear overrides a simultaneous beat and ends the frame
        beat(32'hFFFFFFFF, 1, 0, 32'h11111111, 8'd4);
        chk("clr pre data", data_out, 32'hFFFFFFFF);
        @(negedge clk);
        clear = 1; data_in = 32'h0; in_valid = 1; sof = 0; eof = 0;
        @(posedge clk); #1;
        clear = 0; in_valid = 0;
        chk("clr valid", 32'(out_valid), 32'h0);
        chk("clr data", data_out, 32'h0);
        chk("clr inserted", 32'(inserted), 32'h0);
        beat(32'h00000000, 0, 0, 32'h11111111, 8'd4);
        chk("clr pass", data_out, 32'h0);
        chk("clr pass ins", 32'(inserted), 32'h0);

        // Randomized stream with backpressure vs model
        @(negedge clk); n_rst = 0;
        @(negedge clk); n_rst = 1;
        m_in_frame = 0; m_done = 0; m_w = 0; m_off = 0; m_ip = 0;
        mv = 0; md = 0; ms = 0; me = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            data_in   = $urandom;
            sof       = ($urandom_range(0, 4) == 0);
            eof       = ($urandom_range(0, 3) == 0);
            ip_in     = $urandom;
            offset    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            #1;
            exp_rdy = !mv || out_ready;
            chk("rnd in_ready", 32'(in_ready), 32'(exp_rdy));
            if (in_valid && exp_rdy) begin
                model_step(data_in, sof, eof, ip_in, int'(offset));
                mv = 1; md = e_word; ms = sof; me = eof; mi = e_ins; mt = e_tr;
            end else begin
                if (out_ready) mv = 0;
                mi = 0; mt = 0;
            end
            @(posedge clk); #1;
            chk("rnd valid", 32'(out_valid), 32'(mv));
            chk("rnd inserted", 32'(inserted), 32'(mi));
            chk("rnd trunc", 32'(trunc), 32'(mt));
            if (mv) begin
                chk("rnd data", data_out, md);
                chk("rnd sof", 32'(out_sof), 32'(ms));
                chk("rnd eof", 32'(out_eof), 32'(me));
            end
        end
        in_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
